// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: per-channel 50%-duty divided clock plus
// one-cycle tick, with double-buffered divisors that switch only on a period boundary.
module clock_divider_prog #(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 208332
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [NUM_CH-1:0] div_load,
  output logic [NUM_CH-1:0] dclk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shadow;
    logic             dclk_q;
    logic             tick_q;
    logic             pend_q;
    logic             terminal;

    assign terminal = (cnt == div_act);

    // A load landing on a terminal edge must not be applied there, otherwise the
    // period that the terminal opens would already use a half-captured divisor.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt        <= '0;
        div_act    <= RESET_DIV;
        div_shadow <= RESET_DIV;
        dclk_q     <= 1'b0;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else if (sync) begin
        cnt     <= '0;
        dclk_q  <= 1'b0;
        tick_q  <= 1'b0;
        div_act <= div_shadow;
        if (div_load[i]) begin
          div_shadow <= div_in;
          pend_q     <= 1'b1;
        end else begin
          pend_q <= 1'b0;
        end
      end else begin
        if (en) begin
          if (terminal) begin
            cnt    <= '0;
            dclk_q <= ~dclk_q;
            tick_q <= 1'b1;
            if (pend_q && !div_load[i]) begin
              div_act <= div_shadow;
              pend_q  <= 1'b0;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
        if (div_load[i]) begin
          div_shadow <= div_in;
          pend_q     <= 1'b1;
        end
      end
    end

    assign dclk[i]        = dclk_q;
    assign tick[i]        = tick_q;
    assign div_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: a countdown reference model feeds a scoreboard
// queue each cycle, plus tick-spacing checks against fixed expected period lengths.
module tb_clock_divider_prog;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DEF    = 3;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              en   = 1'b0;
  logic              sync = 1'b0;
  logic [CNT_W-1:0]  div_in   = '0;
  logic [NUM_CH-1:0] div_load = '0;
  logic [NUM_CH-1:0] dclk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;

  clock_divider_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_in(div_in),
    .div_load(div_load), .dclk(dclk), .tick(tick), .div_pending(div_pending)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Model state: rem counts edges left until the next terminal edge.
  int   m_rem  [NUM_CH];
  int   m_div  [NUM_CH];
  int   m_sh   [NUM_CH];
  logic m_pend [NUM_CH];
  logic m_dclk [NUM_CH];
  logic m_tick [NUM_CH];

  typedef struct packed {
    logic [1:0] dclk;
    logic [1:0] tick;
    logic [1:0] pend;
  } exp_t;

  exp_t sb[$];
  int   t0[$];
  int   t1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int gap(input int q[$], input int i);
    if (q.size() < i + 2) return -1;
    return q[i+1] - q[i];
  endfunction

  function automatic int first(input int q[$]);
    if (q.size() < 1) return -1;
    return q[0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_rem[c] = DEF; m_div[c] = DEF; m_sh[c] = DEF;
      m_pend[c] = 1'b0; m_dclk[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic e, input logic s, input logic [1:0] ld, input int d);
    for (int c = 0; c < NUM_CH; c++) begin
      if (s) begin
        m_div[c]  = m_sh[c];
        m_rem[c]  = m_div[c];
        m_dclk[c] = 1'b0;
        m_tick[c] = 1'b0;
        m_pend[c] = 1'b0;
      end else if (!e) begin
        m_tick[c] = 1'b0;
      end else if (m_rem[c] == 0) begin
        if (m_pend[c] && !ld[c]) begin
          m_div[c]  = m_sh[c];
          m_pend[c] = 1'b0;
        end
        m_rem[c]  = m_div[c];
        m_dclk[c] = ~m_dclk[c];
        m_tick[c] = 1'b1;
      end else begin
        m_rem[c]  = m_rem[c] - 1;
        m_tick[c] = 1'b0;
      end
      if (ld[c]) begin
        m_sh[c]   = d;
        m_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [1:0] ld, input int d);
    exp_t expv;
    exp_t got;
    en = e; sync = s; div_load = ld; div_in = CNT_W'(d);
    model_edge(e, s, ld, d);
    expv.dclk = {m_dclk[1], m_dclk[0]};
    expv.tick = {m_tick[1], m_tick[0]};
    expv.pend = {m_pend[1], m_pend[0]};
    sb.push_back(expv);
    @(posedge clk);
    #1;
    cyc++;
    got = {dclk, tick, div_pending};
    check($sformatf("cycle%0d dclk/tick/pend", cyc), 32'(got), 32'(sb.pop_front()));
    if (tick[0]) t0.push_back(cyc);
    if (tick[1]) t1.push_back(cyc);
  endtask

  task automatic idle(input int n, input logic e);
    for (int k = 0; k < n; k++) step(e, 1'b0, 2'b00, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s_cyc;
    int r_cyc;
    int guard;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset dclk", 32'(dclk), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset pend", 32'(div_pending), 32'd0);
    rst = 1'b0;

    // Default divisor: tick every 4 edges, first on the 4th edge after release.
    t0.delete(); t1.delete();
    idle(16, 1'b1);
    check("s1 first tick ch0", 32'(first(t0)), 32'd4);
    check("s1 first tick ch1", 32'(first(t1)), 32'd4);
    check("s1 gap ch0", 32'(gap(t0, 0)), 32'd4);
    check("s1 gap ch1", 32'(gap(t1, 2)), 32'd4);

    // Mid-period load of divisor 1 on ch0.
    idle(1, 1'b1);
    step(1'b1, 1'b0, 2'b01, 1);
    check("s2 pending after load", 32'(div_pending), 32'd1);
    idle(4, 1'b1);
    t0.delete(); t1.delete();
    idle(12, 1'b1);
    check("s2 gap ch0", 32'(gap(t0, 0)), 32'd2);
    check("s2 gap ch0 later", 32'(gap(t0, 3)), 32'd2);
    check("s2 gap ch1", 32'(gap(t1, 0)), 32'd4);

    // Load divisor 5 on ch0 exactly on a terminal edge.
    guard = 0;
    while (m_rem[0] != 0 && guard < 20) begin
      idle(1, 1'b1);
      guard++;
    end
    check("s3 terminal found", 32'(guard < 20), 32'd1);
    t0.delete(); t1.delete();
    step(1'b1, 1'b0, 2'b01, 5);
    check("s3 pending on terminal load", 32'(div_pending[0]), 32'd1);
    idle(10, 1'b1);
    check("s3 old period", 32'(gap(t0, 0)), 32'd2);
    check("s3 new period", 32'(gap(t0, 1)), 32'd6);
    check("s3 pending cleared", 32'(div_pending[0]), 32'd0);

    // Freeze with en=0 then resume.
    idle(3, 1'b1);
    t0.delete(); t1.delete();
    idle(10, 1'b0);
    check("s4 no ticks while frozen", 32'(t0.size() + t1.size()), 32'd0);
    idle(8, 1'b1);

    // Stage 7 on ch1, then restart phase with sync.
    step(1'b1, 1'b0, 2'b10, 7);
    check("s5 ch1 pending", 32'(div_pending), 32'b10);
    idle(2, 1'b1);
    t0.delete(); t1.delete();
    step(1'b1, 1'b1, 2'b00, 0);
    s_cyc = cyc;
    check("s5 dclk after sync", 32'(dclk), 32'd0);
    check("s5 pend after sync", 32'(div_pending), 32'd0);
    idle(17, 1'b1);
    check("s5 ch1 first tick", 32'(first(t1) - s_cyc), 32'd8);
    check("s5 ch1 gap", 32'(gap(t1, 0)), 32'd8);
    check("s5 ch0 first tick", 32'(first(t0) - s_cyc), 32'd6);

    // Async reset mid-period while ch0 has a staged divisor.
    step(1'b1, 1'b0, 2'b01, 9);
    idle(2, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("s6 async dclk", 32'(dclk), 32'd0);
    check("s6 async tick", 32'(tick), 32'd0);
    check("s6 async pend", 32'(div_pending), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_cyc = cyc;
    t0.delete(); t1.delete();
    idle(12, 1'b1);
    check("s6 ch0 first tick", 32'(first(t0) - r_cyc), 32'd4);
    check("s6 ch1 first tick", 32'(first(t1) - r_cyc), 32'd4);
    check("s6 ch0 gap", 32'(gap(t0, 0)), 32'd4);
    check("s6 ch1 gap", 32'(gap(t1, 1)), 32'd4);

    en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
